// File: rtl/vram_responder.sv
// vram_responder: responder side of the video-RAM read interface.
// Holds a 1Kx8 tile RAM and a 1Kx8 palette RAM. Each clock it serves the
// renderer's tile/palette addresses with a two-cycle registered latency. It also
// arbitrates a CPU read/write port into the same RAMs. Video normally owns each
// RAM cycle. A pending CPU access waits for blanking, or for at most MAX_WAIT
// cycles, and then steals one video slot.
//
// Ports:
//   clk, rst                     clock; synchronous reset, active low
//   blank                        1 = renderer blanking, RAM slot is free
//   tile_RAM_addr/palette_RAM_addr  video addresses (16 bit)
//   tile_ROM_addr (8), palette_ROM_addr (6)  registered video read data
//   vid_miss                     outputs repeated this cycle (stolen slot or bad address)
//   cpu_req/we/addr/wdata        CPU request; level, held until cpu_ack
//   cpu_ack, cpu_rdata           completion pulse and read data (held between acks)
//
// CPU FSM
//   state   | meaning
//   IDLE    | waiting for cpu_req; latches the request
//   PEND    | in-window request waiting for a free or stolen slot
//   ACCESS  | RAM cycle owned by the CPU (a dead cycle for out-of-window requests)
//   ACK     | cpu_ack pulse
module vram_responder #(
  parameter logic [15:0] TILE_BASE = 16'h4000,
  parameter logic [15:0] PAL_BASE  = 16'h4400,
  parameter int          MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blank,
  input  logic [15:0] tile_RAM_addr,
  input  logic [15:0] palette_RAM_addr,
  output logic [7:0]  tile_ROM_addr,
  output logic [5:0]  palette_ROM_addr,
  output logic        vid_miss,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_ACCESS, S_ACK} state_t;

  function automatic logic in_win(input logic [15:0] a, input logic [15:0] base);
    logic [16:0] off;
    off = {1'b0, a} - {1'b0, base};
    return (a >= base) && (off < 17'd1024);
  endfunction

  logic [7:0] tile_mem [1024];
  logic [7:0] pal_mem  [1024];

  state_t      state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [9:0]  cpu_idx_q, cpu_idx_d;
  logic        cpu_we_q, cpu_we_d;
  logic [7:0]  cpu_wdata_q, cpu_wdata_d;
  logic        cpu_hit_q, cpu_hit_d;
  logic        cpu_tile_q, cpu_tile_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        v1_valid_q, v1_valid_d;
  logic        v1_miss_q, v1_miss_d;
  logic [7:0]  v1_tile_q, v1_tile_d;
  logic [5:0]  v1_pal_q, v1_pal_d;
  logic [7:0]  tile_out_q, tile_out_d;
  logic [5:0]  pal_out_q, pal_out_d;
  logic        vid_miss_q, vid_miss_d;

  logic        cpu_slot, steal, tile_we, pal_we;
  logic [9:0]  tile_idx, pal_idx;
  logic [7:0]  tile_rd, pal_rd;
  logic        req_tile_hit, req_pal_hit;

  // One address per RAM per cycle: the CPU owns the port in its ACCESS cycle.
  always_comb begin
    cpu_slot     = (state_q == S_ACCESS) && cpu_hit_q;
    steal        = cpu_slot && !blank;
    tile_idx     = (cpu_slot && cpu_tile_q) ? cpu_idx_q : tile_RAM_addr[9:0];
    pal_idx      = (cpu_slot && !cpu_tile_q) ? cpu_idx_q : palette_RAM_addr[9:0];
    tile_rd      = tile_mem[tile_idx];
    pal_rd       = pal_mem[pal_idx];
    // Writes are gated by reset so an access interrupted by reset never commits.
    tile_we      = cpu_slot && cpu_tile_q && cpu_we_q && rst;
    pal_we       = cpu_slot && !cpu_tile_q && cpu_we_q && rst;
    req_tile_hit = in_win(cpu_addr, TILE_BASE);
    req_pal_hit  = in_win(cpu_addr, PAL_BASE);
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    cpu_idx_d   = cpu_idx_q;
    cpu_we_d    = cpu_we_q;
    cpu_wdata_d = cpu_wdata_q;
    cpu_hit_d   = cpu_hit_q;
    cpu_tile_d  = cpu_tile_q;
    cpu_rdata_d = cpu_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          cpu_idx_d   = cpu_addr[9:0];
          cpu_we_d    = cpu_we;
          cpu_wdata_d = cpu_wdata;
          cpu_hit_d   = req_tile_hit || req_pal_hit;
          cpu_tile_d  = req_tile_hit;
          wait_d      = '0;
          // Out-of-window requests pass through a dead ACCESS cycle that touches
          // no RAM and steals nothing, so they ack two cycles after the request.
          state_d     = (req_tile_hit || req_pal_hit) ? S_PEND : S_ACCESS;
        end
      end
      S_PEND: begin
        if (blank || (wait_q == CW'(MAX_WAIT))) state_d = S_ACCESS;
        else                                    wait_d  = wait_q + CW'(1);
      end
      S_ACCESS: begin
        if (!cpu_we_q) cpu_rdata_d = cpu_hit_q ? (cpu_tile_q ? tile_rd : pal_rd) : 8'h00;
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    v1_valid_d = !blank && !steal && in_win(tile_RAM_addr, TILE_BASE)
                 && in_win(palette_RAM_addr, PAL_BASE);
    v1_miss_d  = !blank && !v1_valid_d;
    v1_tile_d  = tile_rd;
    v1_pal_d   = pal_rd[5:0];
    tile_out_d = v1_valid_q ? v1_tile_q : tile_out_q;
    pal_out_d  = v1_valid_q ? v1_pal_q : pal_out_q;
    vid_miss_d = v1_miss_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      cpu_idx_q   <= '0;
      cpu_we_q    <= 1'b0;
      cpu_wdata_q <= '0;
      cpu_hit_q   <= 1'b0;
      cpu_tile_q  <= 1'b0;
      cpu_rdata_q <= '0;
      v1_valid_q  <= 1'b0;
      v1_miss_q   <= 1'b0;
      v1_tile_q   <= '0;
      v1_pal_q    <= '0;
      tile_out_q  <= '0;
      pal_out_q   <= '0;
      vid_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      cpu_idx_q   <= cpu_idx_d;
      cpu_we_q    <= cpu_we_d;
      cpu_wdata_q <= cpu_wdata_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_tile_q  <= cpu_tile_d;
      cpu_rdata_q <= cpu_rdata_d;
      v1_valid_q  <= v1_valid_d;
      v1_miss_q   <= v1_miss_d;
      v1_tile_q   <= v1_tile_d;
      v1_pal_q    <= v1_pal_d;
      tile_out_q  <= tile_out_d;
      pal_out_q   <= pal_out_d;
      vid_miss_q  <= vid_miss_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (tile_we) tile_mem[cpu_idx_q] <= cpu_wdata_q;
    if (pal_we)  pal_mem[cpu_idx_q]  <= cpu_wdata_q;
  end

  assign tile_ROM_addr    = tile_out_q;
  assign palette_ROM_addr = pal_out_q;
  assign vid_miss         = vid_miss_q;
  assign cpu_ack          = (state_q == S_ACK);
  assign cpu_rdata        = cpu_rdata_q;

endmodule

// File: tb/tb_vram_responder.sv
module tb_vram_responder;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        blank = 1'b1;
  logic [15:0] tile_RAM_addr = '0;
  logic [15:0] palette_RAM_addr = '0;
  logic [7:0]  tile_ROM_addr;
  logic [5:0]  palette_ROM_addr;
  logic        vid_miss;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;

  vram_responder #(.TILE_BASE(16'h4000), .PAL_BASE(16'h4400), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .tile_RAM_addr(tile_RAM_addr), .palette_RAM_addr(palette_RAM_addr),
    .tile_ROM_addr(tile_ROM_addr), .palette_ROM_addr(palette_ROM_addr),
    .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int miss_cnt = 0;

  always @(negedge clk) if (vid_miss === 1'b1) miss_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one CPU access from the current cycle; lat = cycles from req to ack (-1 on timeout).
  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                            output int lat, output logic [7:0] rd);
    logic got;
    got = 1'b0;
    cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; rd = 8'h00;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      lat++;
      if (cpu_ack === 1'b1) begin
        rd = cpu_rdata;
        got = 1'b1;
      end
    end
    cpu_req = 1'b0;
    if (!got) lat = -1;
    step();
  endtask

  // Presents one video slot, idles the renderer, and returns at the cycle the result shows.
  task automatic vid_probe(input logic b, input logic [15:0] ta, input logic [15:0] pa);
    blank = b; tile_RAM_addr = ta; palette_RAM_addr = pa;
    step();
    blank = 1'b1; tile_RAM_addr = '0; palette_RAM_addr = '0;
    step();
  endtask

  typedef struct {
    logic        b;
    logic [15:0] ta;
    logic [15:0] pa;
    logic [7:0]  et;
    logic [5:0]  ep;
    logic        em;
  } vec_t;

  vec_t vt[9];

  // ---------------- reference model for the random phase ----------------
  logic [7:0] m_tmem [16];
  logic [7:0] m_pmem [16];
  logic       res_upd [4];
  logic       res_miss [4];
  logic [7:0] res_t [4];
  logic [5:0] res_p [4];
  logic [7:0] exp_tile, exp_rdata, m_rdval;
  logic [5:0] exp_pal;
  logic       exp_miss, exp_ack;
  logic       m_busy, m_inwin, m_we, m_tile;
  int         m_req, m_access, m_ack, m_free, m_idx;
  logic [7:0] m_wdata;

  // 0 = tile window, 1 = palette window, 2 = neither
  function automatic int win(input logic [15:0] a);
    if (a >= 16'h4000 && a < 16'h4400) return 0;
    if (a >= 16'h4400 && a < 16'h4800) return 1;
    return 2;
  endfunction

  function automatic logic [15:0] oow_addr();
    if ($urandom_range(0, 1) == 0) return 16'($urandom_range(0, 16'h3FFF));
    return 16'($urandom_range(16'h4800, 16'hFFFF));
  endfunction

  int         lat;
  logic [7:0] rd;
  int         m0, acks;

  initial begin
    // 1: reset
    rst = 1'b0;
    step(); step();
    chk("rst_tile", tile_ROM_addr, 0);
    chk("rst_pal", palette_ROM_addr, 0);
    chk("rst_miss", vid_miss, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_rdata", cpu_rdata, 0);
    rst = 1'b1;
    step();

    // 2: CPU write/read during blank
    cpu_access(1'b1, 16'h4005, 8'h3C, lat, rd);
    chk("blank_wr_lat", lat, 3);
    cpu_access(1'b0, 16'h4005, 8'h00, lat, rd);
    chk("blank_rd_lat", lat, 3);
    chk("blank_rd_data", rd, 8'h3C);
    cpu_access(1'b1, 16'h4405, 8'h47, lat, rd);
    cpu_access(1'b1, 16'h4006, 8'hA5, lat, rd);
    cpu_access(1'b1, 16'h4406, 8'hFF, lat, rd);
    cpu_access(1'b1, 16'h43FF, 8'h81, lat, rd);
    cpu_access(1'b1, 16'h47FF, 8'hC2, lat, rd);

    // 3: video slot table
    vt[0] = '{1'b0, 16'h4005, 16'h4405, 8'h3C, 6'h07, 1'b0};
    vt[1] = '{1'b0, 16'h4006, 16'h4406, 8'hA5, 6'h3F, 1'b0};
    vt[2] = '{1'b0, 16'h3FFF, 16'h4405, 8'hA5, 6'h3F, 1'b1};
    vt[3] = '{1'b0, 16'h4005, 16'h4800, 8'hA5, 6'h3F, 1'b1};
    vt[4] = '{1'b1, 16'h4005, 16'h4405, 8'hA5, 6'h3F, 1'b0};
    vt[5] = '{1'b0, 16'h4405, 16'h4005, 8'hA5, 6'h3F, 1'b1};
    vt[6] = '{1'b0, 16'h43FF, 16'h47FF, 8'h81, 6'h02, 1'b0};
    vt[7] = '{1'b0, 16'h4400, 16'h4405, 8'h81, 6'h02, 1'b1};
    vt[8] = '{1'b0, 16'h4005, 16'h4405, 8'h3C, 6'h07, 1'b0};
    for (int i = 0; i < 9; i++) begin
      vid_probe(vt[i].b, vt[i].ta, vt[i].pa);
      chk($sformatf("vec%0d_tile", i), tile_ROM_addr, vt[i].et);
      chk($sformatf("vec%0d_pal", i), palette_ROM_addr, vt[i].ep);
      chk($sformatf("vec%0d_miss", i), vid_miss, vt[i].em);
    end

    // 4: starvation limit with continuous video
    blank = 1'b0; tile_RAM_addr = 16'h4005; palette_RAM_addr = 16'h4405;
    step(); step(); step();
    m0 = miss_cnt;
    cpu_access(1'b1, 16'h4006, 8'h5A, lat, rd);
    chk("starve_lat", lat, MAX_WAIT + 3);
    step(); step(); step();
    chk("starve_one_miss", miss_cnt - m0, 1);
    chk("starve_tile_hold", tile_ROM_addr, 8'h3C);
    vid_probe(1'b0, 16'h4006, 16'h4406);
    chk("raw_tile", tile_ROM_addr, 8'h5A);
    chk("raw_pal", palette_ROM_addr, 6'h3F);

    // 5: out-of-window CPU accesses
    blank = 1'b0; tile_RAM_addr = 16'h4005; palette_RAM_addr = 16'h4405;
    step(); step();
    m0 = miss_cnt;
    cpu_access(1'b0, 16'h8000, 8'h00, lat, rd);
    chk("oow_rd_lat", lat, 2);
    chk("oow_rd_data", rd, 8'h00);
    cpu_access(1'b1, 16'h0005, 8'hEE, lat, rd);
    chk("oow_wr_lat", lat, 2);
    step(); step(); step();
    chk("oow_no_miss", miss_cnt - m0, 0);
    blank = 1'b1;
    cpu_access(1'b0, 16'h4005, 8'h00, lat, rd);
    chk("oow_tile_kept", rd, 8'h3C);
    cpu_access(1'b0, 16'h4405, 8'h00, lat, rd);
    chk("oow_pal_kept", rd, 8'h47);

    // 6: reset while a write is in ACCESS
    cpu_we = 1'b1; cpu_addr = 16'h4005; cpu_wdata = 8'h99; cpu_req = 1'b1;
    step();          // PEND
    step();          // ACCESS
    rst = 1'b0; cpu_req = 1'b0;
    step();
    rst = 1'b1;
    chk("rstacc_rdata", cpu_rdata, 0);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_ack === 1'b1) acks++;
      step();
    end
    chk("rstacc_no_ack", acks, 0);
    cpu_access(1'b0, 16'h4005, 8'h00, lat, rd);
    chk("rstacc_old_data", rd, 8'h3C);

    // ---------------- random phase ----------------
    rst = 1'b0; blank = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      m_tmem[i] = 8'($urandom);
      m_pmem[i] = 8'($urandom);
      cpu_access(1'b1, 16'h4000 + 16'(i), m_tmem[i], lat, rd);
      cpu_access(1'b1, 16'h4400 + 16'(i), m_pmem[i], lat, rd);
    end
    step(); step();
    exp_tile = 8'h00; exp_pal = 6'h00; exp_miss = 1'b0; exp_rdata = 8'h00;
    m_busy = 1'b0; m_free = 0; m_access = -1; m_ack = -1; m_req = 0;
    m_inwin = 1'b0; m_we = 1'b0; m_tile = 1'b0; m_idx = 0; m_wdata = 8'h00; m_rdval = 8'h00;
    for (int i = 0; i < 4; i++) begin
      res_upd[i] = 1'b0; res_miss[i] = 1'b0; res_t[i] = 8'h00; res_p[i] = 6'h00;
    end
    for (int t = 0; t < 2000; t++) begin
      int         k;
      int         r;
      int         ti;
      int         pi;
      logic       stolen;
      logic [15:0] a;
      // outputs for cycle t reflect the video slot of cycle t-2
      k = (t + 2) & 3;
      if (res_upd[k]) begin exp_tile = res_t[k]; exp_pal = res_p[k]; end
      exp_miss = res_miss[k];
      exp_ack = m_busy && (t == m_ack);
      if (exp_ack) begin
        if (!m_we) exp_rdata = m_rdval;
        m_busy = 1'b0;
        m_free = t + 1;
      end
      chk("rnd_tile", tile_ROM_addr, exp_tile);
      chk("rnd_pal", palette_ROM_addr, exp_pal);
      chk("rnd_miss", vid_miss, exp_miss);
      chk("rnd_ack", cpu_ack, exp_ack);
      chk("rnd_rdata", cpu_rdata, exp_rdata);

      // stimulus for cycle t
      if (exp_ack) cpu_req = 1'b0;
      else if (!cpu_req && !m_busy && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)      a = 16'h4000 + 16'($urandom_range(0, 15));
        else if (r < 8) a = 16'h4400 + 16'($urandom_range(0, 15));
        else            a = oow_addr();
        cpu_addr = a; cpu_we = 1'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1'b1;
      end
      blank = ($urandom_range(0, 3) == 0);
      tile_RAM_addr    = ($urandom_range(0, 7) != 0) ? 16'h4000 + 16'($urandom_range(0, 15)) : oow_addr();
      palette_RAM_addr = ($urandom_range(0, 7) != 0) ? 16'h4400 + 16'($urandom_range(0, 15)) : oow_addr();

      // model cycle t
      stolen = m_busy && m_inwin && (t == m_access) && !blank;
      ti = int'(tile_RAM_addr) - 16'h4000;
      pi = int'(palette_RAM_addr) - 16'h4400;
      k = t & 3;
      res_upd[k] = 1'b0; res_miss[k] = 1'b0;
      if (!blank) begin
        if (stolen || win(tile_RAM_addr) != 0 || win(palette_RAM_addr) != 1) res_miss[k] = 1'b1;
        else begin
          res_upd[k] = 1'b1;
          res_t[k] = m_tmem[ti];
          res_p[k] = m_pmem[pi][5:0];
        end
      end
      if (m_busy && m_inwin && t == m_access) begin
        if (m_we) begin
          if (m_tile) m_tmem[m_idx] = m_wdata;
          else        m_pmem[m_idx] = m_wdata;
        end else m_rdval = m_tile ? m_tmem[m_idx] : m_pmem[m_idx];
      end
      if (m_busy && m_inwin && m_access < 0 && t >= m_req + 1) begin
        if (blank || (t - (m_req + 1)) == MAX_WAIT) begin
          m_access = t + 1;
          m_ack = t + 2;
        end
      end
      if (!m_busy && cpu_req && t >= m_free) begin
        m_busy = 1'b1; m_req = t; m_access = -1;
        m_we = cpu_we; m_wdata = cpu_wdata;
        m_tile = (win(cpu_addr) == 0);
        m_inwin = (win(cpu_addr) != 2);
        m_idx = m_tile ? int'(cpu_addr) - 16'h4000 : int'(cpu_addr) - 16'h4400;
        if (!m_inwin) begin
          m_ack = t + 2;
          m_rdval = 8'h00;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
